// File: rtl/loop_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loop_seq_pkg
// Description : Shared types and constants for the loop job sequencer.
//               Contains the sequencer state encoding, the default operand
//               width and the number of cycles the kernel reset is held
//               after a timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
package loop_seq_pkg;

    localparam int c_DATA_W       = 10;
    localparam int c_K_RST_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ABORT = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage : loop_seq_pkg
`default_nettype wire

// File: rtl/job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : job_fifo
// Description : Synchronous FIFO holding pending kernel operands.
//               Pointers carry one extra wrap bit; full and empty are
//               registered so the ready path seen upstream is a flop.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push/i_wr_data - write strobe and data (caller keeps !full)
//               i_pop          - read strobe (caller keeps !empty)
//               o_rd_data      - current head entry
//               o_full/o_empty - registered status flags
// Revision    : 1.0 - initial release
// ============================================================================
module job_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int           c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_LEVEL = (c_AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              r_full;
    logic              r_empty;
    logic [c_AW:0]     w_wr_next;
    logic [c_AW:0]     w_rd_next;
    logic [c_AW:0]     w_level_next;

    assign w_wr_next    = r_wr_ptr + {{c_AW{1'b0}}, i_push};
    assign w_rd_next    = r_rd_ptr + {{c_AW{1'b0}}, i_pop};
    // Occupancy after this cycle's push/pop; the extra pointer bit makes
    // the subtraction unambiguous between full and empty.
    assign w_level_next = w_wr_next - w_rd_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_full   <= (w_level_next == c_FULL_LEVEL);
            r_empty  <= (w_level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule : job_fifo
`default_nettype wire

// File: rtl/loop_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : loop_job_sequencer
// Description : Streams operands into the simple-loop kernel one job at a
//               time and returns each kernel result, in job order, on a
//               valid/ready result port.
//               Optional feature macro: LOOP_SEQ_TIMEOUT_EN adds a WAIT
//               timeout that pulses the kernel reset and returns an error
//               result (out_data=0, out_err=1).
// Ports       : clk, rst                  - clock, sync active-high reset
//               in_valid/in_ready/in_n    - job operand stream
//               k_n/k_go/k_rst            - kernel controls
//               k_result/k_result_valid   - kernel result
//               out_valid/out_ready       - result handshake
//               out_data/out_err          - result payload, abort flag
// Revision    : 1.0 - initial release
// ============================================================================
module loop_job_sequencer
    import loop_seq_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_n,
    output logic [DATA_W-1:0] k_n,
    output logic              k_go,
    output logic              k_rst,
    input  logic [DATA_W-1:0] k_result,
    input  logic              k_result_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    state_t            r_state;
    logic [DATA_W-1:0] r_k_n;
    logic              r_k_go;
    logic              r_wait_first;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;

`ifdef LOOP_SEQ_TIMEOUT_EN
    localparam int                 c_TW          = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0]    c_TIMEOUT_VAL = c_TW'(TIMEOUT);
    localparam int                 c_ACW         = (c_K_RST_CYCLES > 1) ? $clog2(c_K_RST_CYCLES) : 1;
    localparam logic [c_ACW-1:0]   c_ABORT_LAST  = c_ACW'(c_K_RST_CYCLES - 1);

    logic [c_TW-1:0]  r_timer;
    logic [c_ACW-1:0] r_abort_cnt;
    logic             r_k_rst;
    logic             r_out_err;
`endif

    assign w_push = in_valid & ~w_fifo_full;
    // Head is consumed on the IDLE->ISSUE transition.
    assign w_pop  = (r_state == IDLE) & ~w_fifo_empty;

    job_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_job_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (in_n),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_k_n        <= '0;
            r_k_go       <= 1'b0;
            r_wait_first <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
`ifdef LOOP_SEQ_TIMEOUT_EN
            r_timer      <= '0;
            r_abort_cnt  <= '0;
            r_k_rst      <= 1'b0;
            r_out_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_k_n   <= w_head;
                        r_k_go  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_k_go       <= 1'b0;
                    // The kernel may still present the previous job's
                    // result_valid during the first WAIT cycle.
                    r_wait_first <= 1'b1;
`ifdef LOOP_SEQ_TIMEOUT_EN
                    r_timer      <= '0;
`endif
                    r_state      <= WAIT;
                end
                WAIT: begin
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && k_result_valid) begin
                        r_out_data  <= k_result;
                        r_out_valid <= 1'b1;
`ifdef LOOP_SEQ_TIMEOUT_EN
                        r_out_err   <= 1'b0;
`endif
                        r_state     <= OUT;
                    end
`ifdef LOOP_SEQ_TIMEOUT_EN
                    else if (r_timer == c_TIMEOUT_VAL) begin
                        r_k_rst     <= 1'b1;
                        r_abort_cnt <= '0;
                        r_state     <= ABORT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end
`ifdef LOOP_SEQ_TIMEOUT_EN
                ABORT: begin
                    if (r_abort_cnt == c_ABORT_LAST) begin
                        r_k_rst     <= 1'b0;
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_abort_cnt <= r_abort_cnt + 1'b1;
                    end
                end
`endif
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ~w_fifo_full;
    assign k_n       = r_k_n;
    assign k_go      = r_k_go;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef LOOP_SEQ_TIMEOUT_EN
    // Kernel reset follows rst directly, plus the abort recovery pulse.
    assign k_rst   = rst | r_k_rst;
    assign out_err = r_out_err;
`else
    assign k_rst   = rst;
    assign out_err = 1'b0;
`endif

endmodule : loop_job_sequencer
`default_nettype wire

// File: tb/tb_loop_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_loop_job_sequencer
// Description : Self-checking bench for loop_job_sequencer with a
//               behavioural model of the simple-loop kernel.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_loop_job_sequencer;

    localparam int DW = 10;

    typedef struct {
        logic [DW-1:0] n;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_n = '0;
    logic [DW-1:0] k_n;
    logic          k_go;
    logic          k_rst;
    logic [DW-1:0] k_result;
    logic          k_result_valid;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_err;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t          sb[$];
    logic [DW-1:0] go_q[$];

    loop_job_sequencer #(
        .DATA_W  (DW),
        .DEPTH   (4),
        .TIMEOUT (1023)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_n           (in_n),
        .k_n            (k_n),
        .k_go           (k_go),
        .k_rst          (k_rst),
        .k_result       (k_result),
        .k_result_valid (k_result_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_err        (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // ---------------- kernel model ----------------
    // Result n+1 appears (n mod 16)+2 cycles after go; result_valid is held
    // until one cycle after the next go, so it is still high (stale) during
    // the first WAIT cycle of the following job.
    logic [DW-1:0] m_res = '0;
    logic [DW-1:0] m_pend = '0;
    logic          m_valid = 1'b0;
    logic          m_drop = 1'b0;
    logic          m_silent = 1'b0;
    int            m_left = 0;

    always @(posedge clk) begin
        if (k_rst) begin
            m_valid <= 1'b0;
            m_drop  <= 1'b0;
            m_left  <= 0;
            m_res   <= '0;
        end else if (k_go) begin
            m_left <= m_silent ? 0 : (int'(k_n) % 16) + 1;
            m_pend <= k_n + 10'd1;
            m_drop <= 1'b1;
        end else begin
            m_drop <= 1'b0;
            if (m_drop) m_valid <= 1'b0;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
            if (m_left > 0) m_left <= m_left - 1;
        end
    end

    assign k_result       = m_res;
    assign k_result_valid = m_valid;

    // ---------------- monitor / scoreboard ----------------
    int   cyc = 0;
    int   go_cyc = 0;
    int   ov_rise_cyc = 0;
    int   krst_cnt = 0;
    int   go_cnt = 0;
    logic prev_go = 1'b0;
    logic prev_ov = 1'b0;
    logic saw_full = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (!in_ready) saw_full = 1'b1;
            if (k_rst) krst_cnt++;
            if (k_go) begin
                go_cyc = cyc;
                go_cnt++;
                check("k_go_single_cycle", prev_go, 1'b0);
                if (go_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL k_go_unexpected: got k_n=%0d expected no issue", k_n);
                end else begin
                    check("k_n", k_n, go_q.pop_front());
                end
            end
            if (out_valid && !prev_ov) ov_rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got out_data=%0d expected no result", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_err", out_err, e.err);
                end
            end
        end
        prev_go = k_go;
        prev_ov = out_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_job(input logic [DW-1:0] n, input logic [DW-1:0] exp, input logic err);
        logic ok;
        int   tries;
        tries = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_n = n;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 3000);
        in_valid = 1'b0;
        if (!ok) begin
            fail_now("push_accept");
        end else begin
            exp_t e;
            e.data = exp;
            e.err  = err;
            go_q.push_back(n);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || out_valid) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= budget) fail_now("drain");
    endtask

    task automatic wait_issued(input int budget);
        int c;
        c = 0;
        while (go_q.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= budget) fail_now("issue");
    endtask

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [DW-1:0] held;

        vecs[0] = '{10'd1,    10'd2};
        vecs[1] = '{10'd2,    10'd3};
        vecs[2] = '{10'd3,    10'd4};
        vecs[3] = '{10'd4,    10'd5};
        vecs[4] = '{10'd5,    10'd6};
        vecs[5] = '{10'd48,   10'd49};
        vecs[6] = '{10'd16,   10'd17};
        vecs[7] = '{10'd1023, 10'd0};
        vecs[8] = '{10'd511,  10'd512};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_k_rst", k_rst, 1'b1);
        check("rst_k_go", k_go, 1'b0);
        check("rst_k_n", k_n, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 1'b0);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("idle_k_rst", k_rst, 1'b0);

        // Single job, fixed latency: result at go+6, registered capture +1
        push_job(10'd900, 10'd901, 1'b0);
        wait_drain(100);
        check("latency_900", ov_rise_cyc - go_cyc, 7);

        // Table: back-to-back stream, FIFO fill, stale-result, wrap
        saw_full = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push_job(vecs[i].n, vecs[i].exp, 1'b0);
        end
        wait_drain(500);
        check("fifo_went_full", saw_full, 1'b1);

        // Output backpressure holds result and blocks the next issue
        out_ready = 1'b0;
        push_job(10'd37, 10'd38, 1'b0);
        push_job(10'd70, 10'd71, 1'b0);
        c = 0;
        while (!out_valid && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 100) fail_now("stall_out_valid");
        held = out_data;
        check("stall_first_data", held, 10'd38);
        c = go_cnt;
        repeat (20) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, held);
        end
        check("stall_no_go", go_cnt - c, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(200);

        // Reset mid-WAIT with jobs queued
        push_job(10'd100, 10'd101, 1'b0);
        wait_issued(20);
        push_job(10'd7, 10'd8, 1'b0);
        push_job(10'd8, 10'd9, 1'b0);
        push_job(10'd9, 10'd10, 1'b0);
        rst = 1'b1;
        go_q.delete();
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_k_go", k_go, 1'b0);
        check("midrst_k_rst", k_rst, 1'b1);
        rst = 1'b0;
        c = go_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("midrst_fifo_empty_no_go", go_cnt - c, 0);
        check("midrst_no_out", out_valid, 1'b0);
        push_job(10'd250, 10'd251, 1'b0);
        wait_drain(100);

`ifdef LOOP_SEQ_TIMEOUT_EN
        // Kernel never answers: abort after TIMEOUT, k_rst pulse, error result
        m_silent = 1'b1;
        krst_cnt = 0;
        push_job(10'd200, 10'd0, 1'b1);
        wait_issued(20);
        m_silent = 1'b0;
        wait_drain(1200);
        check("timeout_latency", ov_rise_cyc - go_cyc, 1027);
        check("timeout_k_rst_cycles", krst_cnt, 2);
        push_job(10'd201, 10'd202, 1'b0);
        wait_drain(100);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_loop_job_sequencer
`default_nettype wire
